// File: rtl/led_display_arbiter.sv
// Shares the 4-digit 7-segment display between two valid/ready writers with timed ownership.
// Optional leading-zero blanking is enabled by defining LED_DISPLAY_ARB_LZB_EN.
module led_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter int unsigned HOLD_WIDTH  = 25
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [15:0] i_req0_value,
  input  logic [3:0]  i_req0_dp,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [15:0] i_req1_value,
  input  logic [3:0]  i_req1_dp,
  output logic [7:0]  o_display_D0,
  output logic [7:0]  o_display_D1,
  output logic [7:0]  o_display_D2,
  output logic [7:0]  o_display_D3,
  output logic        o_owner_valid,
  output logic        o_owner
);

  typedef enum logic [1:0] {
    StIdle  = 2'b01,
    StOwned = 2'b10
  } state_e;

  localparam logic [HOLD_WIDTH-1:0] HoldReload = HOLD_WIDTH'(HOLD_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  rr_q, rr_d;        // 1: req1 favoured on contention
  logic                  owner_q, owner_d;
  logic [HOLD_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0][7:0]       disp_q, disp_d;

  logic        load;
  logic        load_sel;
  logic [15:0] sel_value;
  logic [3:0]  sel_dp;
  logic [3:0]  blank;

  // Active-low {a..g} for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [7:0] b;
    unique case (nib)
      4'h0: b = 8'h03;
      4'h1: b = 8'h9F;
      4'h2: b = 8'h25;
      4'h3: b = 8'h0D;
      4'h4: b = 8'h99;
      4'h5: b = 8'h49;
      4'h6: b = 8'h41;
      4'h7: b = 8'h1F;
      4'h8: b = 8'h01;
      4'h9: b = 8'h09;
      4'hA: b = 8'h11;
      4'hB: b = 8'hC1;
      4'hC: b = 8'h63;
      4'hD: b = 8'h85;
      4'hE: b = 8'h61;
      4'hF: b = 8'h71;
    endcase
    return b[7:1];
  endfunction

  assign sel_value = load_sel ? i_req1_value : i_req0_value;
  assign sel_dp    = load_sel ? i_req1_dp    : i_req0_dp;

`ifdef LED_DISPLAY_ARB_LZB_EN
  always_comb begin
    blank    = '0;
    blank[3] = (sel_value[15:12] == 4'h0);
    blank[2] = blank[3] && (sel_value[11:8] == 4'h0);
    blank[1] = blank[2] && (sel_value[7:4] == 4'h0);
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    disp_d       = disp_q;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    load         = 1'b0;
    load_sel     = 1'b0;

    // Synchronous reset: drop any handshake in the reset cycle.
    if (i_reset_n) begin
      case (state_q)
        StIdle: begin
          if (i_req0_valid && (!i_req1_valid || !rr_q)) begin
            o_req0_ready = 1'b1;
          end else if (i_req1_valid) begin
            o_req1_ready = 1'b1;
          end
          if (o_req0_ready || o_req1_ready) begin
            load     = 1'b1;
            load_sel = o_req1_ready;
            owner_d  = o_req1_ready;
            rr_d     = ~o_req1_ready;
            cnt_d    = HoldReload;
            state_d  = StOwned;
          end
        end
        StOwned: begin
          o_req0_ready = ~owner_q;
          o_req1_ready = owner_q;
          load_sel     = owner_q;
          if (owner_q ? i_req1_valid : i_req0_valid) begin
            load  = 1'b1;
            cnt_d = HoldReload;
          end else if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (load) begin
      for (int n = 0; n < 4; n++) begin
        disp_d[n] = {seg_decode(sel_value[4*n +: 4]) | {7{blank[n]}}, ~sel_dp[n]};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      disp_q  <= {4{8'hFF}};
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
    end
  end

  assign o_display_D0  = disp_q[0];
  assign o_display_D1  = disp_q[1];
  assign o_display_D2  = disp_q[2];
  assign o_display_D3  = disp_q[3];
  assign o_owner_valid = (state_q == StOwned);
  assign o_owner       = owner_q;

endmodule

// File: tb/tb_led_display_arbiter.sv
// Directed self-checking bench for led_display_arbiter with a 4-cycle ownership window.
module tb_led_display_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_req0_valid, i_req1_valid;
  logic        o_req0_ready, o_req1_ready;
  logic [15:0] i_req0_value, i_req1_value;
  logic [3:0]  i_req0_dp, i_req1_dp;
  logic [7:0]  o_display_D0, o_display_D1, o_display_D2, o_display_D3;
  logic        o_owner_valid, o_owner;

  int n_compared   = 0;
  int n_mismatched = 0;

`ifdef LED_DISPLAY_ARB_LZB_EN
  localparam logic [31:0] Exp0007 = 32'hFFFFFF1F;
`else
  localparam logic [31:0] Exp0007 = 32'h0303031F;
`endif

  led_display_arbiter #(
    .HOLD_CYCLES(4),
    .HOLD_WIDTH (3)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_req0_valid (i_req0_valid),
    .o_req0_ready (o_req0_ready),
    .i_req0_value (i_req0_value),
    .i_req0_dp    (i_req0_dp),
    .i_req1_valid (i_req1_valid),
    .o_req1_ready (o_req1_ready),
    .i_req1_value (i_req1_value),
    .i_req1_dp    (i_req1_dp),
    .o_display_D0 (o_display_D0),
    .o_display_D1 (o_display_D1),
    .o_display_D2 (o_display_D2),
    .o_display_D3 (o_display_D3),
    .o_owner_valid(o_owner_valid),
    .o_owner      (o_owner)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks happen 1 unit later still.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] disp();
    return {o_display_D3, o_display_D2, o_display_D1, o_display_D0};
  endfunction

  logic [15:0] rw_val [3];
  logic [3:0]  rw_dp  [3];
  logic [31:0] rw_exp [3];

  initial begin
    rw_val[0] = 16'h5678; rw_dp[0] = 4'b0000; rw_exp[0] = 32'h49411F01;
    rw_val[1] = 16'h9ABC; rw_dp[1] = 4'b1111; rw_exp[1] = 32'h0810C062;
    rw_val[2] = 16'hDEF0; rw_dp[2] = 4'b1010; rw_exp[2] = 32'h84617003;

    i_reset_n    = 1'b0;
    i_req0_valid = 1'b0; i_req0_value = '0; i_req0_dp = '0;
    i_req1_valid = 1'b0; i_req1_value = '0; i_req1_dp = '0;
    tick();
    tick();
    i_reset_n = 1'b1;
    #1;
    check_eq("reset_disp", disp(), 32'hFFFFFFFF);
    check_eq("reset_owner_valid", 32'(o_owner_valid), 32'd0);
    check_eq("reset_owner", 32'(o_owner), 32'd0);
    check_eq("idle_ready0", 32'(o_req0_ready), 32'd0);
    check_eq("idle_ready1", 32'(o_req1_ready), 32'd0);

    // Single write from req0.
    i_req0_valid = 1'b1; i_req0_value = 16'h1234; i_req0_dp = 4'b0001;
    #1;
    check_eq("w1_ready0", 32'(o_req0_ready), 32'd1);
    check_eq("w1_ready1", 32'(o_req1_ready), 32'd0);
    tick();
    i_req0_valid = 1'b0;
    check_eq("w1_disp", disp(), 32'h9F250D98);
    check_eq("w1_owner_valid", 32'(o_owner_valid), 32'd1);
    check_eq("w1_owner", 32'(o_owner), 32'd0);
    repeat (4) tick();
    check_eq("expire_owner_valid", 32'(o_owner_valid), 32'd0);
    check_eq("expire_disp_kept", disp(), 32'h9F250D98);

    // Contention straight out of reset: req0 wins.
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    i_req0_valid = 1'b1; i_req0_value = 16'hABCD; i_req0_dp = 4'b0000;
    i_req1_valid = 1'b1; i_req1_value = 16'h0007; i_req1_dp = 4'b0000;
    #1;
    check_eq("cont_ready0", 32'(o_req0_ready), 32'd1);
    check_eq("cont_ready1", 32'(o_req1_ready), 32'd0);
    tick();
    i_req0_valid = 1'b0;
    check_eq("cont_disp", disp(), 32'h11C16385);
    check_eq("cont_owner", 32'(o_owner), 32'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("lockout_ready1_%0d", i), 32'(o_req1_ready), 32'd0);
      check_eq($sformatf("lockout_owner_valid_%0d", i), 32'(o_owner_valid), 32'd1);
      tick();
    end
    // Second contention: req1 was not granted last, so it wins.
    i_req0_valid = 1'b1;
    #1;
    check_eq("rr_owner_valid", 32'(o_owner_valid), 32'd0);
    check_eq("rr_ready1", 32'(o_req1_ready), 32'd1);
    check_eq("rr_ready0", 32'(o_req0_ready), 32'd0);
    tick();
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    check_eq("rr_owner", 32'(o_owner), 32'd1);
    check_eq("rr_disp_0007", disp(), Exp0007);

    // Let req1 expire, then req0 owns and rewrites every 3 cycles under req1 pressure.
    repeat (4) tick();
    check_eq("exp2_owner_valid", 32'(o_owner_valid), 32'd0);
    i_req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_req0_valid = 1'b1; i_req0_value = rw_val[k]; i_req0_dp = rw_dp[k];
      #1;
      check_eq($sformatf("rw_ready0_%0d", k), 32'(o_req0_ready), 32'd1);
      check_eq($sformatf("rw_ready1_%0d", k), 32'(o_req1_ready), 32'd0);
      tick();
      i_req0_valid = 1'b0;
      check_eq($sformatf("rw_disp_%0d", k), disp(), rw_exp[k]);
      check_eq($sformatf("rw_owner_%0d", k), 32'({o_owner_valid, o_owner}), 32'b10);
      for (int j = 0; j < 2; j++) begin
        #1;
        check_eq($sformatf("rw_hold_ready1_%0d_%0d", k, j), 32'(o_req1_ready), 32'd0);
        tick();
      end
    end

    // Reset mid-ownership: the pending owner write is dropped.
    i_reset_n = 1'b0;
    i_req0_valid = 1'b1; i_req0_value = 16'h1111;
    #1;
    check_eq("rst_ready0", 32'(o_req0_ready), 32'd0);
    check_eq("rst_ready1", 32'(o_req1_ready), 32'd0);
    tick();
    i_reset_n = 1'b1;
    i_req0_valid = 1'b0;
    #1;
    check_eq("rst_disp", disp(), 32'hFFFFFFFF);
    check_eq("rst_owner_valid", 32'(o_owner_valid), 32'd0);
    check_eq("post_rst_ready1", 32'(o_req1_ready), 32'd1);
    tick();
    i_req1_valid = 1'b0;
    check_eq("post_rst_owner", 32'({o_owner_valid, o_owner}), 32'b11);
    check_eq("post_rst_disp", disp(), Exp0007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
